// File: rtl/sm_trace_monitor.sv
// sm_trace_monitor
//   On-chip debug monitor for the sm_cpu core. While the core runs it records
//   {pc, instr} into a circular trace buffer and counts cycles. Capture freezes
//   on a pc-match trigger or when the cycle count reaches NCYCLE. On dump_req
//   it streams the trace (oldest first, tag 0), then sweeps the data RAM
//   (tag 1) over a valid/ready port, and parks in DONE until reset.
// Ports
//   clk, rst             clock and synchronous active-high reset
//   cap_en               core running; capture and counting only when high
//   pc, instr            current core pc / instruction
//   trig_en, trig_pc     pc-match trigger enable and address
//   dump_req             level request to start streaming from HOLD
//   ram_addr, ram_data   debug RAM read port (data valid in the same cycle)
//   out_valid/ready/tag/data  output stream; data is {pc,instr} or RAM word
//   cycle_cnt            saturating count of captured cycles
//   timeout, triggered, wrapped  sticky status flags
//   state_o              current FSM state
module sm_trace_monitor #(
  parameter int TRACE_AW = 5,
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int RAM_AW   = 4,
  parameter int RAM_DW   = 8,
  parameter int NCYCLE   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_en,
  input  logic [PC_W-1:0]         pc,
  input  logic [INSTR_W-1:0]      instr,
  input  logic                    trig_en,
  input  logic [PC_W-1:0]         trig_pc,
  input  logic                    dump_req,
  output logic [RAM_AW-1:0]       ram_addr,
  input  logic [RAM_DW-1:0]       ram_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_tag,
  output logic [PC_W+INSTR_W-1:0] out_data,
  output logic [31:0]             cycle_cnt,
  output logic                    timeout,
  output logic                    triggered,
  output logic                    wrapped,
  output logic [2:0]              state_o
);

  localparam int EW = PC_W + INSTR_W;
  localparam int DEPTH = 1 << TRACE_AW;
  localparam logic [TRACE_AW:0] DEPTH_C = (TRACE_AW + 1)'(DEPTH);
  localparam logic [TRACE_AW:0] ONE_C = (TRACE_AW + 1)'(1);
  localparam logic [31:0] NCYCLE_M1 = 32'(NCYCLE - 1);

  typedef enum logic [2:0] {
    S_CAPTURE    = 3'd0,
    S_HOLD       = 3'd1,
    S_DUMP_TRACE = 3'd2,
    S_DUMP_RAM   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t state;

  logic [EW-1:0]       trace_mem [DEPTH];
  logic [TRACE_AW-1:0] wr_ptr;
  logic [TRACE_AW-1:0] rd_ptr;
  logic [TRACE_AW:0]   count;
  logic [TRACE_AW:0]   rd_left;   // entries still to be accepted, incl. the one presented

  logic cap_write;
  logic hit_trig;
  logic hit_timeout;

  assign cap_write   = (state == S_CAPTURE) && cap_en && !rst;
  assign hit_trig    = trig_en && (pc == trig_pc);
  // the cycle being counted now is the NCYCLE-th one
  assign hit_timeout = (cycle_cnt == NCYCLE_M1);
  assign state_o     = state;

  // Trace storage: single write port, contents never reset.
  always_ff @(posedge clk) begin
    if (cap_write) begin
      trace_mem[wr_ptr] <= {pc, instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CAPTURE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_left   <= '0;
      cycle_cnt <= '0;
      ram_addr  <= '0;
      out_valid <= 1'b0;
      out_tag   <= 1'b0;
      out_data  <= '0;
      timeout   <= 1'b0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (cap_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count == DEPTH_C) begin
              wrapped <= 1'b1;
            end else begin
              count <= count + ONE_C;
            end
            if (cycle_cnt != '1) begin
              cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (hit_trig) begin
              triggered <= 1'b1;
            end
            if (hit_timeout) begin
              timeout <= 1'b1;
            end
            if (hit_trig || hit_timeout) begin
              state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (dump_req) begin
            if (count == '0) begin
              state    <= S_DUMP_RAM;
              ram_addr <= '0;
            end else begin
              state   <= S_DUMP_TRACE;
              // once the buffer has wrapped, wr_ptr points at the oldest entry
              rd_ptr  <= wrapped ? wr_ptr : '0;
              rd_left <= count;
            end
          end
        end

        S_DUMP_TRACE: begin
          if (!out_valid) begin
            // first entry: one cycle after entering the state
            out_valid <= 1'b1;
            out_tag   <= 1'b0;
            out_data  <= trace_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
          end else if (out_ready) begin
            if (rd_left == ONE_C) begin
              out_valid <= 1'b0;
              state     <= S_DUMP_RAM;
              ram_addr  <= '0;
            end else begin
              // reload straight away so a continuously ready sink sees no gaps
              out_data <= trace_mem[rd_ptr];
              rd_ptr   <= rd_ptr + 1'b1;
              rd_left  <= rd_left - ONE_C;
            end
          end
        end

        S_DUMP_RAM: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_tag   <= 1'b1;
            out_data  <= EW'(ram_data);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (ram_addr == '1) begin
              state <= S_DONE;
            end else begin
              ram_addr <= ram_addr + 1'b1;
            end
          end
        end

        S_DONE: begin
          out_valid <= 1'b0;
        end

        default: begin
          state <= S_CAPTURE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_trace_monitor.sv
// Bench for sm_trace_monitor: captures traces under trigger/timeout, then
// consumes the dump stream against a queue of expected words.
module tb_sm_trace_monitor;

  localparam int TRACE_AW = 5;
  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int RAM_AW   = 4;
  localparam int RAM_DW   = 8;
  localparam int NCYCLE   = 40;
  localparam int EW       = PC_W + INSTR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                cap_en;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  instr;
  logic                trig_en;
  logic [PC_W-1:0]     trig_pc;
  logic                dump_req;
  logic [RAM_AW-1:0]   ram_addr;
  logic [RAM_DW-1:0]   ram_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_tag;
  logic [EW-1:0]       out_data;
  logic [31:0]         cycle_cnt;
  logic                timeout;
  logic                triggered;
  logic                wrapped;
  logic [2:0]          state_o;

  logic [RAM_DW-1:0]   ram [16];

  typedef struct packed {
    logic              tag;
    logic [EW-1:0]     data;
    logic [RAM_AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;

  always #5 clk = ~clk;

  assign ram_data = ram[ram_addr];

  sm_trace_monitor #(
    .TRACE_AW(TRACE_AW), .PC_W(PC_W), .INSTR_W(INSTR_W),
    .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .NCYCLE(NCYCLE)
  ) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .instr(instr),
    .trig_en(trig_en), .trig_pc(trig_pc), .dump_req(dump_req),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .cycle_cnt(cycle_cnt), .timeout(timeout),
    .triggered(triggered), .wrapped(wrapped), .state_o(state_o)
  );

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] p);
    return (p * 32'h0001_0003) ^ 32'hA5C3_0F00;
  endfunction

  task automatic do_reset();
    rst = 1'b1; cap_en = 1'b0; trig_en = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
    pc = '0; instr = '0; trig_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cap_cycle(input logic en, input logic [PC_W-1:0] p);
    cap_en = en; pc = p; instr = instr_of(p);
    @(negedge clk);
  endtask

  task automatic push_trace(input logic [PC_W-1:0] p);
    exp_t e;
    e.tag = 1'b0; e.data = {p, instr_of(p)}; e.addr = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_ram();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.tag = 1'b1; e.data = EW'(15 - i); e.addr = RAM_AW'(i);
      exp_q.push_back(e);
    end
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
  // stop_word >= 0: return (ready low) when that RAM word is presented.
  task automatic run_dump(input int mode, input int ntrace, input int stop_word);
    int cyc = 0;
    int first_t = -1;
    int last_t = -1;
    logic held = 1'b0;
    logic [EW-1:0] held_data = '0;
    exp_t e;
    dump_req = 1'b1; cap_en = 1'b0;
    @(negedge clk);
    dump_req = 1'b0;
    check_cnt++;
    if (state_o !== 3'd2) $display("FAIL dump_entry_state: got %0d expected 2", state_o);
    else pass_cnt++;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (mode == 0) out_ready = 1'b1;
      else out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (held) begin
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== held_data)
          $display("FAIL stall_hold: got valid=%0b data=%h expected valid=1 data=%h",
                   out_valid, out_data, held_data);
        else pass_cnt++;
      end
      if (out_valid === 1'b1 && stop_word >= 0 && out_tag === 1'b1 && int'(ram_addr) == stop_word) begin
        out_ready = 1'b0;
        return;
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = exp_q.pop_front();
        check_cnt++;
        if (out_tag !== e.tag || out_data !== e.data)
          $display("FAIL stream_word: got tag=%0b data=%h expected tag=%0b data=%h",
                   out_tag, out_data, e.tag, e.data);
        else pass_cnt++;
        if (e.tag) begin
          check_cnt++;
          if (ram_addr !== e.addr)
            $display("FAIL ram_addr: got %0d expected %0d", ram_addr, e.addr);
          else pass_cnt++;
        end else begin
          if (first_t < 0) first_t = cyc;
          last_t = cyc;
        end
      end
      held = (out_valid === 1'b1) && !out_ready;
      held_data = out_data;
      @(negedge clk);
      cyc++;
    end
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL dump_budget: got %0d words left expected 0", exp_q.size());
    else pass_cnt++;
    if (mode == 0) begin
      check_cnt++;
      if (last_t - first_t != ntrace - 1)
        $display("FAIL no_bubble: got span %0d expected %0d", last_t - first_t, ntrace - 1);
      else pass_cnt++;
    end
    check_cnt++;
    if (state_o !== 3'd4 || out_valid !== 1'b0)
      $display("FAIL done_state: got state=%0d valid=%0b expected state=4 valid=0", state_o, out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (state_o !== 3'd4 || out_valid !== 1'b0)
      $display("FAIL done_stays: got state=%0d valid=%0b expected state=4 valid=0", state_o, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cap_en = 1'b1; pc = 32'd3; instr = '0; trig_en = 1'b0; trig_pc = '0;
    dump_req = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_cnt++;
    if (state_o !== 3'd0 || out_valid !== 1'b0 || out_tag !== 1'b0 || out_data !== '0)
      $display("FAIL reset_out: got state=%0d valid=%0b tag=%0b data=%h expected 0 0 0 0",
               state_o, out_valid, out_tag, out_data);
    else pass_cnt++;
    check_cnt++;
    if (cycle_cnt !== 32'd0 || ram_addr !== '0)
      $display("FAIL reset_cnt: got cycle_cnt=%0d ram_addr=%0d expected 0 0", cycle_cnt, ram_addr);
    else pass_cnt++;
    check_cnt++;
    if ({timeout, triggered, wrapped} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {timeout, triggered, wrapped});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_trigger();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'd5;
    for (int i = 0; i < 6; i++) cap_cycle(1'b1, PC_W'(i));
    check_cnt++;
    if (state_o !== 3'd1 || triggered !== 1'b1 || timeout !== 1'b0 || wrapped !== 1'b0)
      $display("FAIL trig_hold: got state=%0d trig=%0b to=%0b wr=%0b expected 1 1 0 0",
               state_o, triggered, timeout, wrapped);
    else pass_cnt++;
    check_cnt++;
    if (cycle_cnt !== 32'd6) $display("FAIL trig_cycles: got %0d expected 6", cycle_cnt);
    else pass_cnt++;
    // capture must stay frozen in HOLD
    cap_cycle(1'b1, 32'd77);
    cap_cycle(1'b1, 32'd78);
    check_cnt++;
    if (cycle_cnt !== 32'd6 || state_o !== 3'd1)
      $display("FAIL hold_frozen: got cycle_cnt=%0d state=%0d expected 6 1", cycle_cnt, state_o);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) push_trace(PC_W'(i));
    push_ram();
    run_dump(0, 6, -1);
  endtask

  task automatic test_timeout_wrap();
    do_reset();
    trig_en = 1'b0;
    for (int i = 0; i < 39; i++) cap_cycle(1'b1, PC_W'(i));
    check_cnt++;
    if (state_o !== 3'd0 || timeout !== 1'b0 || cycle_cnt !== 32'd39)
      $display("FAIL pre_timeout: got state=%0d to=%0b cnt=%0d expected 0 0 39",
               state_o, timeout, cycle_cnt);
    else pass_cnt++;
    cap_cycle(1'b1, 32'd39);
    cap_en = 1'b0;
    check_cnt++;
    if (state_o !== 3'd1 || timeout !== 1'b1 || triggered !== 1'b0 || wrapped !== 1'b1 || cycle_cnt !== 32'd40)
      $display("FAIL timeout_hold: got state=%0d to=%0b trig=%0b wr=%0b cnt=%0d expected 1 1 0 1 40",
               state_o, timeout, triggered, wrapped, cycle_cnt);
    else pass_cnt++;
    for (int i = 8; i < 40; i++) push_trace(PC_W'(i));
    push_ram();
    run_dump(1, 32, -1);
  endtask

  task automatic test_trig_timeout_gaps();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'd139;
    for (int k = 0; k < 40; k++) begin
      if ((k % 5) == 0 || k == 39) cap_cycle(1'b0, 32'd139);
      if (k == 39) begin
        check_cnt++;
        if (state_o !== 3'd0 || triggered !== 1'b0 || cycle_cnt !== 32'd39)
          $display("FAIL gap_ignored: got state=%0d trig=%0b cnt=%0d expected 0 0 39",
                   state_o, triggered, cycle_cnt);
        else pass_cnt++;
      end
      cap_cycle(1'b1, PC_W'(100 + k));
    end
    cap_en = 1'b0;
    check_cnt++;
    if (state_o !== 3'd1 || timeout !== 1'b1 || triggered !== 1'b1 || cycle_cnt !== 32'd40)
      $display("FAIL both_flags: got state=%0d to=%0b trig=%0b cnt=%0d expected 1 1 1 40",
               state_o, timeout, triggered, cycle_cnt);
    else pass_cnt++;
    for (int k = 8; k < 40; k++) push_trace(PC_W'(100 + k));
    push_ram();
    run_dump(0, 32, -1);
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'd2;
    for (int i = 0; i < 3; i++) cap_cycle(1'b1, PC_W'(i));
    for (int i = 0; i < 3; i++) push_trace(PC_W'(i));
    push_ram();
    run_dump(0, 3, 7);
    check_cnt++;
    if (exp_q.size() != 9) $display("FAIL mid_dump_reach: got %0d words left expected 9", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; cap_en = 1'b0;
    check_cnt++;
    if (state_o !== 3'd0 || out_valid !== 1'b0 || out_tag !== 1'b0 || out_data !== '0 || ram_addr !== '0)
      $display("FAIL abort_out: got state=%0d valid=%0b tag=%0b data=%h addr=%0d expected all 0",
               state_o, out_valid, out_tag, out_data, ram_addr);
    else pass_cnt++;
    check_cnt++;
    if ({timeout, triggered, wrapped} !== 3'b000 || cycle_cnt !== 32'd0)
      $display("FAIL abort_flags: got flags=%b cnt=%0d expected 000 0",
               {timeout, triggered, wrapped}, cycle_cnt);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cnt++;
      if (out_valid !== 1'b0) $display("FAIL abort_quiet: got valid=%0b expected 0", out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = RAM_DW'(15 - i);
    test_reset();
    test_trigger();
    test_timeout_wrap();
    test_trig_timeout_gaps();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
